// File: rtl/ad7606_pkg.sv
// Shared constants and types for the AD7606 host-link framing (command decoder and response framer).
package ad7606_pkg;

    localparam logic [7:0] HEADER    = 8'h55;
    localparam logic [7:0] TYPE_SEEK = 8'd5;
    localparam logic [7:0] TYPE_DONE = 8'd6;

    localparam logic [7:0] SEEK_LEN = 8'd6;
    localparam logic [7:0] DONE_LEN = 8'd2;
    localparam int         MAX_LEN  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_TYPE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } resp_state_t;

endpackage

// File: rtl/ad7606_resp_arb.sv
// Pending-request latch for seek/done events with fixed seek-over-done priority.
module ad7606_resp_arb
    import ad7606_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cap_seek,
    input  logic       i_cap_done,
    input  logic       i_take,
    output logic       o_grant,
    output logic       o_sel_seek,
    output logic [7:0] o_sel_type
);

    logic pend_seek_reg, pend_seek_next;
    logic pend_done_reg, pend_done_next;

    // A new pulse is ORed in after the clear, so a pulse landing on the take edge survives.
    always_comb begin
        pend_seek_next = i_cap_seek | (pend_seek_reg & ~i_take);
        pend_done_next = i_cap_done | (pend_done_reg & ~(i_take & ~pend_seek_reg));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_seek_reg <= 1'b0;
            pend_done_reg <= 1'b0;
        end else begin
            pend_seek_reg <= pend_seek_next;
            pend_done_reg <= pend_done_next;
        end
    end

    assign o_grant    = pend_seek_reg | pend_done_reg;
    assign o_sel_seek = pend_seek_reg;
    assign o_sel_type = pend_seek_reg ? TYPE_SEEK : TYPE_DONE;

endmodule

// File: rtl/ad7606_resp_pack.sv
// Response framer: HEADER, TYPE, LEN, payload bytes over a valid/ready byte stream.
// Optional trailing checksum byte enabled by defining RESP_CHECKSUM_EN.
module ad7606_resp_pack
    import ad7606_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cap_seek,
    input  logic        i_cap_done,
    input  logic [15:0] i_cap_cnt,
    input  logic [7:0]  i_cap_chnnel_num,
    input  logic [23:0] i_cap_speed,
    input  logic        i_cap_enable,
    input  logic        i_cap_trigger,
    output logic [7:0]  o_resp_data,
    output logic [7:0]  o_resp_len,
    output logic        o_resp_last,
    output logic        o_resp_valid,
    input  logic        i_resp_ready
);

    logic        grant;
    logic        sel_seek;
    logic [7:0]  sel_type;
    logic        take;
    logic        hs;
    logic        last_payload;

    resp_state_t state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  len_reg;
    logic [7:0]  type_reg;
    logic [7:0]  payload_reg [0:MAX_LEN-1];
    logic [7:0]  snap [0:MAX_LEN-1];
    logic [7:0]  snap_len;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]  csum_reg;
    logic [7:0]  snap_sum;
`endif

    ad7606_resp_arb u_arb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cap_seek (i_cap_seek),
        .i_cap_done (i_cap_done),
        .i_take     (take),
        .o_grant    (grant),
        .o_sel_seek (sel_seek),
        .o_sel_type (sel_type)
    );

    assign take = (state_reg == ST_IDLE) && grant;
    assign hs   = o_resp_valid && i_resp_ready;

    // Payload image captured at frame start; unused slots stay zero.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) snap[i] = '0;
        snap_len = DONE_LEN;
        if (sel_seek) begin
            snap[0]  = i_cap_chnnel_num;
            snap[1]  = i_cap_speed[23:16];
            snap[2]  = i_cap_speed[15:8];
            snap[3]  = i_cap_speed[7:0];
            snap[4]  = {7'b0, i_cap_enable};
            snap[5]  = {7'b0, i_cap_trigger};
            snap_len = SEEK_LEN;
        end else begin
            snap[0] = i_cap_cnt[15:8];
            snap[1] = i_cap_cnt[7:0];
        end
    end

`ifdef RESP_CHECKSUM_EN
    always_comb begin
        snap_sum = sel_type + snap_len;
        for (int i = 0; i < MAX_LEN; i++) snap_sum = snap_sum + snap[i];
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            len_reg   <= '0;
            type_reg  <= '0;
            for (int i = 0; i < MAX_LEN; i++) payload_reg[i] <= '0;
`ifdef RESP_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (take) begin
                len_reg  <= snap_len;
                type_reg <= sel_type;
                for (int i = 0; i < MAX_LEN; i++) payload_reg[i] <= snap[i];
`ifdef RESP_CHECKSUM_EN
                csum_reg <= snap_sum;
`endif
            end
        end
    end

    assign last_payload = ({5'b0, idx_reg} == (len_reg - 8'd1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_HEAD;
                    idx_next   = '0;
                end
            end
            ST_HEAD:    if (hs) state_next = ST_TYPE;
            ST_TYPE:    if (hs) state_next = ST_LEN;
            ST_LEN: begin
                if (hs) begin
                    state_next = ST_PAYLOAD;
                    idx_next   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    if (last_payload) begin
`ifdef RESP_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_IDLE;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
`ifdef RESP_CHECKSUM_EN
            ST_CSUM:    if (hs) state_next = ST_IDLE;
`endif
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so they hold while ready is low.
    always_comb begin
        o_resp_valid = (state_reg != ST_IDLE);
        o_resp_data  = '0;
        o_resp_last  = 1'b0;
        case (state_reg)
            ST_HEAD:    o_resp_data = HEADER;
            ST_TYPE:    o_resp_data = type_reg;
            ST_LEN:     o_resp_data = len_reg;
            ST_PAYLOAD: begin
                o_resp_data = payload_reg[idx_reg];
`ifndef RESP_CHECKSUM_EN
                o_resp_last = last_payload;
`endif
            end
`ifdef RESP_CHECKSUM_EN
            ST_CSUM: begin
                o_resp_data = csum_reg;
                o_resp_last = 1'b1;
            end
`endif
            default:    o_resp_data = '0;
        endcase
    end

    assign o_resp_len = len_reg;

endmodule

// File: tb/tb_ad7606_resp_pack.sv
// Self-checking bench for ad7606_resp_pack: vector table, corner sequences and random frames vs a byte-list model.
module tb_ad7606_resp_pack;

    logic        i_clk;
    logic        i_rst;
    logic        i_cap_seek;
    logic        i_cap_done;
    logic [15:0] i_cap_cnt;
    logic [7:0]  i_cap_chnnel_num;
    logic [23:0] i_cap_speed;
    logic        i_cap_enable;
    logic        i_cap_trigger;
    logic [7:0]  o_resp_data;
    logic [7:0]  o_resp_len;
    logic        o_resp_last;
    logic        o_resp_valid;
    logic        i_resp_ready;

    ad7606_resp_pack dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cap_seek       (i_cap_seek),
        .i_cap_done       (i_cap_done),
        .i_cap_cnt        (i_cap_cnt),
        .i_cap_chnnel_num (i_cap_chnnel_num),
        .i_cap_speed      (i_cap_speed),
        .i_cap_enable     (i_cap_enable),
        .i_cap_trigger    (i_cap_trigger),
        .o_resp_data      (o_resp_data),
        .o_resp_len       (o_resp_len),
        .o_resp_last      (o_resp_last),
        .o_resp_valid     (o_resp_valid),
        .i_resp_ready     (i_resp_ready)
    );

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;

    logic [7:0] got_q[$];
    bit         got_last_q[$];
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];

    bit         hold_pend = 0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [7:0] hold_len;

    typedef struct {
        bit          is_seek;
        logic [7:0]  chn;
        logic [23:0] speed;
        logic        en;
        logic        trig;
        logic [15:0] cnt;
        int          n;
        logic [7:0]  b [0:8];
        int          rmode;
    } vec_t;

    vec_t vt [0:3];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        i_resp_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_resp_ready = 1'b1;
                1:       i_resp_ready = ~i_resp_ready;
                default: i_resp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte collector plus hold-stability check while the sink stalls.
    always @(negedge i_clk) begin
        if (i_rst) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", o_resp_valid, 1'b1);
                check("hold_data", o_resp_data, hold_data);
                check("hold_last", o_resp_last, hold_last);
                check("hold_len", o_resp_len, hold_len);
            end
            hold_pend = o_resp_valid && !i_resp_ready;
            hold_data = o_resp_data;
            hold_last = o_resp_last;
            hold_len  = o_resp_len;
            if (o_resp_valid && i_resp_ready) begin
                got_q.push_back(o_resp_data);
                got_last_q.push_back(o_resp_last);
            end
        end
    end

    task automatic push_frame(input logic [7:0] fb[$]);
        logic [7:0] sum;
        logic [7:0] fr[$];
        fr = fb;
`ifdef RESP_CHECKSUM_EN
        sum = 8'd0;
        for (int i = 1; i < fr.size(); i++) sum = sum + fr[i];
        fr.push_back(sum);
`else
        sum = 8'd0;
`endif
        for (int i = 0; i < fr.size(); i++) begin
            exp_q.push_back(fr[i]);
            exp_last_q.push_back(i == fr.size() - 1);
        end
    endtask

    task automatic model_frame(input bit is_seek, input logic [7:0] chn, input logic [23:0] spd,
                               input logic en, input logic trig, input logic [15:0] cnt);
        logic [7:0] fb[$];
        fb.push_back(8'h55);
        if (is_seek) begin
            fb.push_back(8'd5);
            fb.push_back(8'd6);
            fb.push_back(chn);
            fb.push_back(8'((spd / 65536) % 256));
            fb.push_back(8'((spd / 256) % 256));
            fb.push_back(8'(spd % 256));
            fb.push_back(en ? 8'd1 : 8'd0);
            fb.push_back(trig ? 8'd1 : 8'd0);
        end else begin
            fb.push_back(8'd6);
            fb.push_back(8'd2);
            fb.push_back(8'(cnt / 256));
            fb.push_back(8'(cnt % 256));
        end
        push_frame(fb);
    endtask

    task automatic set_cfg(input logic [7:0] chn, input logic [23:0] spd, input logic en,
                           input logic trig, input logic [15:0] cnt);
        i_cap_chnnel_num = chn;
        i_cap_speed      = spd;
        i_cap_enable     = en;
        i_cap_trigger    = trig;
        i_cap_cnt        = cnt;
    endtask

    task automatic pulse(input bit s, input bit d);
        @(posedge i_clk);
        #1;
        i_cap_seek = s;
        i_cap_done = d;
        @(posedge i_clk);
        #1;
        i_cap_seek = 1'b0;
        i_cap_done = 1'b0;
    endtask

    task automatic wait_got(input string name, input int n, input int budget);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes required %0d", name, got_q.size(), n);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        wait_got(name, exp_q.size(), budget);
        repeat (6) @(negedge i_clk);
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
            check($sformatf("%s_last%0d", name, i), got_last_q[i], exp_last_q[i]);
        end
        $display("frame %s: %0d bytes checked", name, n);
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        logic [7:0] fb[$];
        int         cyc;
        bit         seen;

        vt[0] = '{1'b1, 8'h04, 24'h0186A0, 1'b1, 1'b0, 16'h0000, 9,
                  '{8'h55, 8'h05, 8'h06, 8'h04, 8'h01, 8'h86, 8'hA0, 8'h01, 8'h00}, 0};
        vt[1] = '{1'b0, 8'h00, 24'h000000, 1'b0, 1'b0, 16'h1234, 5,
                  '{8'h55, 8'h06, 8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 1};
        vt[2] = '{1'b1, 8'h10, 24'hABCDEF, 1'b0, 1'b1, 16'h0000, 9,
                  '{8'h55, 8'h05, 8'h06, 8'h10, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h01}, 2};
        vt[3] = '{1'b0, 8'h3C, 24'h123456, 1'b1, 1'b1, 16'hFF00, 5,
                  '{8'h55, 8'h06, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2};

        i_rst      = 1'b1;
        i_cap_seek = 1'b0;
        i_cap_done = 1'b0;
        set_cfg(8'h00, 24'h0, 1'b0, 1'b0, 16'h0);
        @(negedge i_clk);
        check("rst_valid", o_resp_valid, 1'b0);
        check("rst_data", o_resp_data, 8'h00);
        check("rst_last", o_resp_last, 1'b0);
        check("rst_len", o_resp_len, 8'h00);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);

        // Table-driven vectors.
        for (int k = 0; k < 4; k++) begin
            fb.delete();
            for (int i = 0; i < vt[k].n; i++) fb.push_back(vt[k].b[i]);
            push_frame(fb);
            ready_mode = vt[k].rmode;
            set_cfg(vt[k].chn, vt[k].speed, vt[k].en, vt[k].trig, vt[k].cnt);
            pulse(vt[k].is_seek, !vt[k].is_seek);
            drain($sformatf("vec%0d", k), 200);
        end
        ready_mode = 0;

        // Latency: pulse sampled at E0, valid visible after E1.
        set_cfg(8'h04, 24'h0186A0, 1'b1, 1'b0, 16'h0);
        model_frame(1'b1, 8'h04, 24'h0186A0, 1'b1, 1'b0, 16'h0);
        @(posedge i_clk);
        #1;
        i_cap_seek = 1'b1;
        @(posedge i_clk);
        #1;
        i_cap_seek = 1'b0;
        @(negedge i_clk);
        check("lat_e0_valid", o_resp_valid, 1'b0);
        @(negedge i_clk);
        check("lat_e1_valid", o_resp_valid, 1'b1);
        check("lat_e1_data", o_resp_data, 8'h55);
        check("lat_e1_len", o_resp_len, 8'd6);
        drain("latency", 100);

        // Simultaneous seek and done: seek first, one idle cycle, then done.
        set_cfg(8'h08, 24'h00FF01, 1'b0, 1'b1, 16'hBEEF);
        model_frame(1'b1, 8'h08, 24'h00FF01, 1'b0, 1'b1, 16'hBEEF);
        model_frame(1'b0, 8'h08, 24'h00FF01, 1'b0, 1'b1, 16'hBEEF);
        pulse(1'b1, 1'b1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 50) begin
            @(negedge i_clk);
            seen = o_resp_valid && i_resp_ready && o_resp_last;
            cyc++;
        end
        check("both_first_last_seen", seen, 1'b1);
        @(negedge i_clk);
        check("both_gap_idle", o_resp_valid, 1'b0);
        @(negedge i_clk);
        check("both_second_valid", o_resp_valid, 1'b1);
        check("both_second_len", o_resp_len, 8'd2);
        drain("seek_then_done", 100);

        // Two seeks while busy merge into one extra frame.
        set_cfg(8'h02, 24'h000064, 1'b1, 1'b1, 16'h0);
        model_frame(1'b1, 8'h02, 24'h000064, 1'b1, 1'b1, 16'h0);
        model_frame(1'b1, 8'h02, 24'h000064, 1'b1, 1'b1, 16'h0);
        pulse(1'b1, 1'b0);
        repeat (2) @(posedge i_clk);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        drain("merged_seeks", 100);

        // Mid-payload config change stays out of the in-flight frame.
        set_cfg(8'h04, 24'h0186A0, 1'b1, 1'b0, 16'h0);
        model_frame(1'b1, 8'h04, 24'h0186A0, 1'b1, 1'b0, 16'h0);
        pulse(1'b1, 1'b0);
        wait_got("snap_wait", 5, 50);
        i_cap_speed = 24'hFFFFFF;
        drain("snapshot_old", 100);
        model_frame(1'b1, 8'h04, 24'hFFFFFF, 1'b1, 1'b0, 16'h0);
        pulse(1'b1, 1'b0);
        drain("snapshot_new", 100);

        // Asynchronous reset in PAYLOAD drops the frame.
        pulse(1'b1, 1'b0);
        wait_got("rst_wait", 5, 50);
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_valid", o_resp_valid, 1'b0);
        check("midrst_data", o_resp_data, 8'h00);
        check("midrst_last", o_resp_last, 1'b0);
        check("midrst_len", o_resp_len, 8'h00);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        repeat (3) @(posedge i_clk);
        check("post_rst_idle", o_resp_valid, 1'b0);
        set_cfg(8'h07, 24'h01E240, 1'b0, 1'b1, 16'h0);
        model_frame(1'b1, 8'h07, 24'h01E240, 1'b0, 1'b1, 16'h0);
        pulse(1'b1, 1'b0);
        drain("post_reset", 100);

        // Random frames with random backpressure.
        ready_mode = 2;
        for (int r = 0; r < 30; r++) begin
            int kind;
            logic [7:0]  chn;
            logic [23:0] spd;
            logic        en;
            logic        trig;
            logic [15:0] cnt;
            kind = $urandom_range(0, 2);
            chn  = 8'($urandom);
            spd  = 24'($urandom);
            en   = 1'($urandom_range(0, 1));
            trig = 1'($urandom_range(0, 1));
            cnt  = 16'($urandom);
            set_cfg(chn, spd, en, trig, cnt);
            if (kind != 1) model_frame(1'b1, chn, spd, en, trig, cnt);
            if (kind != 0) model_frame(1'b0, chn, spd, en, trig, cnt);
            pulse(kind != 1, kind != 0);
            drain($sformatf("rand%0d", r), 400);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
